wb_trace_fifo: RTL

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

---
 rtl/wb_trace_fifo_pkg.sv | 29 ++
 rtl/wb_trace_fifo_sync_fifo.sv | 73 +++++++
 rtl/wb_trace_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_trace_fifo_pkg.sv
// Shared constants and types for the write-back trace FIFO: record layout,
// beat framing and the serializer state encoding.
package wb_trace_fifo_pkg;

    localparam int          BEATS        = 5;
    localparam int          BEAT_W       = $clog2(BEATS);
    localparam int          BEAT_DATA_W  = 32;
    localparam int          PAYLOAD_W    = 128;
    localparam logic [7:0]  HDR_DEFAULT  = 8'hA5;

    typedef struct packed {
        logic [7:0]  seq;
        logic [4:0]  wnum;
        logic [7:0]  we;
        logic [63:0] pc;
        logic [63:0] wdata;
    } trace_rec_t;

    // {seq, wnum, we, pc, wdata} packs to 149 bits; the store width follows the struct.
    localparam int REC_W = $bits(trace_rec_t);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/wb_trace_fifo_sync_fifo.sv
// Synchronous FIFO with a registered, first-word-fall-through head output.
// The head register is loaded from the address that will be the head after this edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_addr_next;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = head_reg;

    // A push into a full store is legal only when the head leaves in the same cycle.
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign rd_addr_next = do_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Bypass covers a write landing on the slot that becomes the head.
    always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == rd_addr_next)) begin
            head_reg <= push_data;
        end else begin
            head_reg <= mem[rd_addr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_addr_next;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures retiring register writes into a record FIFO and streams each record
// as five 32-bit beats on a valid/ready port, with sequence numbering and drop accounting.
module wb_trace_fifo
    import wb_trace_fifo_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter logic [7:0] HDR   = HDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic [63:0] debug_wb_pc,
    input  logic [7:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [63:0] debug_wb_rf_wdata,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic [31:0] tr_data,
    output logic        tr_last,
    output logic        ovf,
    output logic [15:0] drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    tx_state_t             state_reg;
    tx_state_t             state_next;
    logic [BEAT_W-1:0]     beat_reg;
    logic [BEAT_W-1:0]     beat_next;
    logic [7:0]            seq_reg;
    logic                  ovf_reg;
    logic [15:0]           drop_cnt_reg;

    trace_rec_t            rec_in;
    trace_rec_t            head_rec;
    logic [REC_W-1:0]      head_bits;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                  capture;
    logic                  handshake;
    logic                  last_hs;
    logic                  push;
    logic                  drop;

    logic [PAYLOAD_W-1:0]  payload;
    logic [BEAT_DATA_W-1:0] beat_word [BEATS];

    assign capture   = trace_en && (debug_wb_rf_we != 8'h00);
    assign handshake = tr_valid && tr_ready;
    assign last_hs   = handshake && (beat_reg == LAST_BEAT);
    // The slot freed by a finishing record is reusable in the same cycle.
    assign push      = capture && (!fifo_full || last_hs);
    assign drop      = capture && !push;

    always_comb begin
        rec_in       = '0;
        rec_in.seq   = seq_reg;
        rec_in.wnum  = debug_wb_rf_wnum;
        rec_in.we    = debug_wb_rf_we;
        rec_in.pc    = debug_wb_pc;
        rec_in.wdata = debug_wb_rf_wdata;
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rec_in),
        .pop       (last_hs),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_rec = head_bits;
    assign payload  = {head_rec.wdata, head_rec.pc};

    assign beat_word[0] = {HDR, head_rec.seq, 3'b000, head_rec.wnum, head_rec.we};
    for (genvar gi = 1; gi < BEATS; gi++) begin : g_payload_beat
        assign beat_word[gi] = payload[(gi-1)*BEAT_DATA_W +: BEAT_DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    // A push in the same cycle counts as non-empty so beat0 appears one cycle after capture.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_next = ST_SEND;
                    beat_next  = '0;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (beat_reg == LAST_BEAT) begin
                        beat_next = '0;
                        if ((fifo_count <= CNT_W'(1)) && !push) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_comb begin
        tr_valid = (state_reg == ST_SEND);
        tr_last  = (state_reg == ST_SEND) && (beat_reg == LAST_BEAT);
        tr_data  = '0;
        if (state_reg == ST_SEND) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_reg == BEAT_W'(i)) begin
                    tr_data = beat_word[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg      <= '0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (capture) begin
                seq_reg <= seq_reg + 8'd1;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
                if (drop_cnt_reg != 16'hFFFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign ovf      = ovf_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule
